// File: rtl/psum_accumulator.sv
// Accumulates a programmable number of signed partial-sum beats, then presents
// the saturated result on a valid/ready output and holds it until consumed.
module psum_accumulator #(
  parameter int unsigned psum_bw = 16,
  parameter int unsigned acc_bw  = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [3:0]         len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [psum_bw-1:0] in_psum,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [psum_bw-1:0] out,
  output logic               ovf
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAcc  = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [acc_bw-1:0]  acc_q, acc_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [4:0]         tgt_q, tgt_d;
  logic [psum_bw-1:0] out_q, out_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;
  logic               accept;
  logic               enter_hold;
  logic [acc_bw-1:0]  psum_ext;
  logic [psum_bw:0]   sat;

  // Returns {clipped, value}; the acc fits iff all bits above the result sign agree.
  function automatic logic [psum_bw:0] saturate(input logic [acc_bw-1:0] a);
    logic [acc_bw-psum_bw:0] upper;
    upper = a[acc_bw-1:psum_bw-1];
    if ((&upper) || (~|upper)) begin
      saturate = {1'b0, a[psum_bw-1:0]};
    end else if (a[acc_bw-1]) begin
      saturate = {1'b1, 1'b1, {(psum_bw-1){1'b0}}};
    end else begin
      saturate = {1'b1, 1'b0, {(psum_bw-1){1'b1}}};
    end
  endfunction

  assign psum_ext = {{(acc_bw-psum_bw){in_psum[psum_bw-1]}}, in_psum};
  // Reset forces in_ready high combinationally so it reads 1 throughout reset.
  assign in_ready = reset || (state_q != StHold);
  assign accept   = in_valid && (state_q != StHold);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    out_d      = out_q;
    ovf_d      = ovf_q;
    valid_d    = valid_q;
    enter_hold = 1'b0;
    sat        = '0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          acc_d = psum_ext;
          tgt_d = (len == 4'd0) ? 5'd16 : {1'b0, len};
          cnt_d = 5'd1;
          if (tgt_d == 5'd1) begin
            enter_hold = 1'b1;
          end else begin
            state_d = StAcc;
          end
        end
      end
      StAcc: begin
        if (accept) begin
          acc_d = acc_q + psum_ext;
          cnt_d = cnt_q + 5'd1;
          if (cnt_d == tgt_q) begin
            enter_hold = 1'b1;
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
          valid_d = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (enter_hold) begin
      sat     = saturate(acc_d);
      state_d = StHold;
      out_d   = sat[psum_bw-1:0];
      ovf_d   = sat[psum_bw];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (clear) begin
      // Abort keeps the latched length; it is reloaded on the next first beat.
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out       = out_q;
  assign ovf       = ovf_q;

endmodule
